// File: rtl/abh_pkg.sv
// Shared select encodings for the address-high stage; also consumed by the microcode ROM generator.
package abh_pkg;

    localparam logic [1:0] BASE_ZERO = 2'b00;
    localparam logic [1:0] BASE_PCH  = 2'b01;
    localparam logic [1:0] BASE_AHH  = 2'b10;
    localparam logic [1:0] BASE_DB   = 2'b11;

    localparam logic [1:0] OFF_ZERO  = 2'b00;
    localparam logic [1:0] OFF_ABH   = 2'b01;
    localparam logic [1:0] OFF_SIGN  = 2'b10;
    localparam logic [1:0] OFF_ONE   = 2'b11;

    // 8-bit incrementer with wrap; the carry out is intentionally dropped.
    function automatic logic [7:0] inc8(input logic [7:0] value, input logic carry);
        inc8 = value + {7'b0000000, carry};
    endfunction

endpackage

// File: rtl/abh_add.sv
// Address-high adder: base mux + offset mux + 8-bit add with carry from ABL; purely combinational.
module abh_add
    import abh_pkg::*;
(
    input  logic [1:0] base_sel,
    input  logic [1:0] off_sel,
    input  logic [7:0] pch,
    input  logic [7:0] ahh,
    input  logic [7:0] db,
    input  logic [7:0] abh,
    input  logic       cond,
    input  logic       ci,
    output logic [7:0] adh
);

    logic [7:0] base_s;
    logic [7:0] off_s;
    logic [8:0] sum_s;

    // Base operand selection.
    always_comb begin
        base_s = 8'h00;
        case (base_sel)
            BASE_ZERO: base_s = 8'h00;
            BASE_PCH:  base_s = pch;
            BASE_AHH:  base_s = ahh;
            BASE_DB:   base_s = db;
            default:   base_s = 8'h00;
        endcase
    end

    // Offset operand selection; OFF_SIGN sign-extends a branch offset into the high byte.
    always_comb begin
        off_s = 8'h00;
        case (off_sel)
            OFF_ZERO: off_s = 8'h00;
            OFF_ABH:  off_s = abh;
            OFF_SIGN: off_s = {8{cond}};
            OFF_ONE:  off_s = 8'h01;
            default:  off_s = 8'h00;
        endcase
    end

    assign sum_s = {1'b0, base_s} + {1'b0, off_s} + {8'h00, ci};
    assign adh   = sum_s[7:0];

endmodule

// File: rtl/abh.sv
// Address Bus High stage: forms ADH/ABH in lock-step with ABL and holds AHH and PCH.
// Optional feature macro ABH_PAGE_X_EN: registered page-crossing flag; otherwise page_x is 1'b0.
module abh
    import abh_pkg::*;
#(
    parameter logic [7:0] ABH_RST = 8'hFF,
    parameter logic [7:0] PCH_RST = 8'h00
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       CI,
    input  logic       cond,
    input  logic [7:0] DB,
    input  logic [3:0] op,
    input  logic       ld_ahh,
    input  logic       ld_pc,
    input  logic       pcl_co,
    output logic [7:0] PCH,
    output logic [7:0] ADH,
    output logic [7:0] ABH,
    output logic       page_x
);

    logic [7:0] abh_r;
    logic [7:0] pch_r;
    logic [7:0] ahh_r;
    logic [7:0] adh_s;
    logic [7:0] pch_next_s;
    logic [7:0] ahh_next_s;

    abh_add u_add (
        .base_sel (op[3:2]),
        .off_sel  (op[1:0]),
        .pch      (pch_r),
        .ahh      (ahh_r),
        .db       (DB),
        .abh      (abh_r),
        .cond     (cond),
        .ci       (CI),
        .adh      (adh_s)
    );

    // Hold-register next values; PCH increments from the registered ABH, mirroring PCL.
    always_comb begin
        pch_next_s = pch_r;
        ahh_next_s = ahh_r;
        if (ld_pc) begin
            pch_next_s = inc8(abh_r, pcl_co);
        end else begin
            pch_next_s = pch_r;
        end
        if (ld_ahh) begin
            ahh_next_s = DB;
        end else begin
            ahh_next_s = ahh_r;
        end
    end

    // State registers; reset overrides every load.
    always_ff @(posedge clk) begin
        if (RST) begin
            abh_r <= ABH_RST;
            pch_r <= PCH_RST;
            ahh_r <= 8'h00;
        end else begin
            abh_r <= adh_s;
            pch_r <= pch_next_s;
            ahh_r <= ahh_next_s;
        end
    end

`ifdef ABH_PAGE_X_EN
    logic page_x_r;
    logic page_x_next_s;

    // Page crossing: a carry on indexed adds, or carry disagreeing with a backward branch sign.
    always_comb begin
        page_x_next_s = 1'b0;
        if (op[1:0] == OFF_ABH) begin
            page_x_next_s = CI;
        end else if (op[1:0] == OFF_SIGN) begin
            page_x_next_s = CI ^ cond;
        end else begin
            page_x_next_s = 1'b0;
        end
    end

    // One-cycle page-crossing flag for the microcode sequencer.
    always_ff @(posedge clk) begin
        if (RST) begin
            page_x_r <= 1'b0;
        end else begin
            page_x_r <= page_x_next_s;
        end
    end

    assign page_x = page_x_r;
`else
    assign page_x = 1'b0;
`endif

    assign ADH = adh_s;
    assign ABH = abh_r;
    assign PCH = pch_r;

endmodule

// File: tb/tb_abh.sv
// Self-checking bench for abh: directed vector table followed by randomized cycles against a reference model.
module tb_abh;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       CI = 1'b0;
    logic       cond = 1'b0;
    logic [7:0] DB = 8'h00;
    logic [3:0] op = 4'h0;
    logic       ld_ahh = 1'b0;
    logic       ld_pc = 1'b0;
    logic       pcl_co = 1'b0;
    logic [7:0] PCH;
    logic [7:0] ADH;
    logic [7:0] ABH;
    logic       page_x;

    int n_cmp = 0;
    int n_bad = 0;

    abh dut (
        .clk    (clk),
        .RST    (RST),
        .CI     (CI),
        .cond   (cond),
        .DB     (DB),
        .op     (op),
        .ld_ahh (ld_ahh),
        .ld_pc  (ld_pc),
        .pcl_co (pcl_co),
        .PCH    (PCH),
        .ADH    (ADH),
        .ABH    (ABH),
        .page_x (page_x)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ci;
        logic       cnd;
        logic [7:0] db;
        logic [3:0] op;
        logic       la;
        logic       lp;
        logic       pco;
        logic       chk_adh;
        logic [7:0] adh;
        logic [7:0] abh;
        logic [7:0] pch;
        logic       px;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic px_exp(input logic v);
`ifdef ABH_PAGE_X_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic void add(input logic rst, ci, cnd, input logic [7:0] db, input logic [3:0] o,
                                input logic la, lp, pco, chk, input logic [7:0] adh, abh, pch,
                                input logic px);
        vec_t v;
        v.rst = rst; v.ci = ci; v.cnd = cnd; v.db = db; v.op = o; v.la = la; v.lp = lp; v.pco = pco;
        v.chk_adh = chk; v.adh = adh; v.abh = abh; v.pch = pch; v.px = px;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, ci, cnd, input logic [7:0] db, input logic [3:0] o,
                         input logic la, lp, pco);
        RST = rst; CI = ci; cond = cnd; DB = db; op = o; ld_ahh = la; ld_pc = lp; pcl_co = pco;
    endtask

    // Reference model state
    int m_abh, m_pch, m_ahh, m_px;

    function automatic int model_adh(input logic [3:0] o, input logic ci, cnd, input logic [7:0] db);
        int b, f;
        if (o[3:2] == 2'd0) b = 0;
        else if (o[3:2] == 2'd1) b = m_pch;
        else if (o[3:2] == 2'd2) b = m_ahh;
        else b = db;
        if (o[1:0] == 2'd0) f = 0;
        else if (o[1:0] == 2'd1) f = m_abh;
        else if (o[1:0] == 2'd2) f = cnd ? 255 : 0;
        else f = 1;
        return (b + f + ci) % 256;
    endfunction

    initial begin
        int a;
        logic r, c, cd, la, lp, pco;
        logic [7:0] d;
        logic [3:0] o;

        //   rst ci cnd db     op       la lp pco chk adh    abh    pch    px
        add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 0);
        add(1, 0, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 8'h00, 8'hFF, 8'h00, 0);
        add(0, 0, 0, 8'h12, 4'b0000, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 0, 8'h00, 4'b1000, 0, 0, 0, 1, 8'h13, 8'h13, 8'h00, 0);
        add(0, 0, 0, 8'h20, 4'b1100, 0, 0, 0, 1, 8'h20, 8'h20, 8'h00, 0);
        add(0, 1, 0, 8'h00, 4'b0001, 0, 0, 0, 1, 8'h21, 8'h21, 8'h00, 1);
        add(0, 0, 0, 8'h00, 4'b0001, 0, 0, 0, 1, 8'h21, 8'h21, 8'h00, 0);
        add(0, 0, 0, 8'h80, 4'b1100, 0, 0, 0, 1, 8'h80, 8'h80, 8'h00, 0);
        add(0, 0, 0, 8'hFF, 4'b1100, 0, 1, 1, 1, 8'hFF, 8'hFF, 8'h81, 0);
        add(0, 0, 0, 8'h40, 4'b1100, 0, 1, 1, 1, 8'h40, 8'h40, 8'h00, 0);
        add(0, 0, 0, 8'h00, 4'b0000, 0, 1, 0, 1, 8'h00, 8'h00, 8'h40, 0);
        add(0, 1, 1, 8'h00, 4'b0110, 0, 0, 0, 1, 8'h40, 8'h40, 8'h40, 0);
        add(0, 0, 1, 8'h00, 4'b0110, 0, 0, 0, 1, 8'h3F, 8'h3F, 8'h40, 1);
        add(0, 0, 0, 8'h00, 4'b0011, 0, 0, 0, 1, 8'h01, 8'h01, 8'h40, 0);
        add(1, 0, 0, 8'h00, 4'b0011, 0, 0, 0, 1, 8'h01, 8'hFF, 8'h00, 0);
        add(0, 1, 0, 8'h00, 4'b0001, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1);
        add(0, 0, 0, 8'hFF, 4'b1100, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0);
        add(0, 1, 1, 8'hFF, 4'b1110, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0);
        add(0, 0, 0, 8'h00, 4'b0001, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0);
        add(0, 0, 0, 8'h00, 4'b0100, 0, 1, 0, 1, 8'h00, 8'h00, 8'hFF, 0);
        add(0, 1, 0, 8'h00, 4'b0100, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 0);
        add(0, 0, 0, 8'h55, 4'b0000, 1, 1, 1, 1, 8'h00, 8'h00, 8'h01, 0);
        add(0, 0, 0, 8'h00, 4'b1000, 0, 0, 0, 1, 8'h55, 8'h55, 8'h01, 0);
        add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00, 0);
        add(0, 0, 0, 8'h00, 4'b1000, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ci, vecs[i].cnd, vecs[i].db, vecs[i].op,
                  vecs[i].la, vecs[i].lp, vecs[i].pco);
            #1;
            if (vecs[i].chk_adh) check($sformatf("vec%0d ADH", i), ADH, vecs[i].adh);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ABH", i), ABH, vecs[i].abh);
            check($sformatf("vec%0d PCH", i), PCH, vecs[i].pch);
            check($sformatf("vec%0d page_x", i), page_x, px_exp(vecs[i].px));
        end

        // Randomized phase, starting from a known reset
        drive(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        m_abh = 255; m_pch = 0; m_ahh = 0; m_px = 0;
        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(0, 15) == 0);
            c   = $urandom_range(0, 1);
            cd  = $urandom_range(0, 1);
            d   = 8'($urandom_range(0, 255));
            o   = 4'($urandom_range(0, 15));
            la  = $urandom_range(0, 1);
            lp  = $urandom_range(0, 1);
            pco = $urandom_range(0, 1);
            drive(r, c, cd, d, o, la, lp, pco);
            a = model_adh(o, c, cd, d);
            #1;
            check("rnd ADH", ADH, a);
            @(posedge clk);
            #1;
            if (r) begin
                m_abh = 255; m_pch = 0; m_ahh = 0; m_px = 0;
            end else begin
                if (lp) m_pch = (m_abh + pco) % 256;
                if (la) m_ahh = d;
                m_abh = a;
                if (o[1:0] == 2'd1) m_px = c;
                else if (o[1:0] == 2'd2) m_px = (c != cd);
                else m_px = 0;
            end
            check("rnd ABH", ABH, m_abh);
            check("rnd PCH", PCH, m_pch);
            check("rnd page_x", page_x, px_exp(m_px[0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
